// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the memory macro.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  // CPU requester
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  // DMA/IO requester
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  // Memory macro
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  // Status
  logic          owner_dma;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner_dma
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner_dma
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port data memory between the CPU datapath and
// a DMA/IO requester. CPU has fixed priority; DMA is forced through after
// STARVE_LIMIT consecutive CPU wins while it waits. Every granted access runs
// IDLE -> ACCESS -> WAIT (WAIT_STATES cycles, skipped when 0) -> DONE -> IDLE
// and finishes with a one-cycle ack to its owner.
module mem_arbiter #(
  parameter int DW           = 16,
  parameter int AW           = 16,
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);
  // WAIT counts WAIT_STATES-1 down to 0; unused when WAIT_STATES is 0.
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         r_state;
  logic [3:0]     r_wait_cnt;
  logic [SCW-1:0] r_starve_cnt;
  logic           r_mem_en;
  logic           r_mem_we;
  logic [AW-1:0]  r_mem_addr;
  logic [DW-1:0]  r_mem_wdata;
  logic           r_owner_dma;
  logic           r_cpu_ack;
  logic           r_dma_ack;
  logic [DW-1:0]  r_cpu_rdata;
  logic [DW-1:0]  r_dma_rdata;

  logic           w_starved;
  logic           w_dma_win;
  logic           w_cpu_win;
  logic           w_last;

  // Arbitration: DMA only wins when the CPU is quiet or DMA has been starved.
  assign w_starved = (r_starve_cnt == STARVE_MAX);
  assign w_dma_win = bus.dma_req && (!bus.cpu_req || w_starved);
  assign w_cpu_win = bus.cpu_req && !w_dma_win;

  // Last cycle before DONE: memory read data is valid on this cycle's edge,
  // exactly WAIT_STATES cycles after the mem_en cycle.
  assign w_last = ((r_state == S_ACCESS) && (WAIT_STATES == 0)) ||
                  ((r_state == S_WAIT) && (r_wait_cnt == 4'd0));

  // Access sequencer with registered memory strobe, acks, read data and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_owner_dma  <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_dma_ack    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dma_win) begin
            r_state      <= S_ACCESS;
            r_owner_dma  <= 1'b1;
            r_mem_en     <= 1'b1;
            r_mem_we     <= bus.dma_we;
            r_mem_addr   <= bus.dma_addr;
            r_mem_wdata  <= bus.dma_wdata;
            r_starve_cnt <= '0;
          end else if (w_cpu_win) begin
            r_state      <= S_ACCESS;
            r_owner_dma  <= 1'b0;
            r_mem_en     <= 1'b1;
            r_mem_we     <= bus.cpu_we;
            r_mem_addr   <= bus.cpu_addr;
            r_mem_wdata  <= bus.cpu_wdata;
            // A CPU win over a waiting DMA cannot reach past STARVE_MAX,
            // because at STARVE_MAX the DMA takes the grant instead.
            r_starve_cnt <= bus.dma_req ? (r_starve_cnt + SCW'(1)) : '0;
          end else begin
            // No request at all means DMA is not waiting.
            r_starve_cnt <= '0;
          end
        end

        S_ACCESS: begin
          r_mem_en   <= 1'b0;
          r_mem_we   <= 1'b0;
          r_wait_cnt <= WAIT_INIT;
          if (w_last) begin
            r_state <= S_DONE;
            if (r_owner_dma) begin
              r_dma_rdata <= bus.mem_rdata;
              r_dma_ack   <= 1'b1;
            end else begin
              r_cpu_rdata <= bus.mem_rdata;
              r_cpu_ack   <= 1'b1;
            end
          end else begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (w_last) begin
            r_state <= S_DONE;
            if (r_owner_dma) begin
              r_dma_rdata <= bus.mem_rdata;
              r_dma_ack   <= 1'b1;
            end else begin
              r_cpu_rdata <= bus.mem_rdata;
              r_cpu_ack   <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end

        S_DONE: begin
          // Requests are not sampled here; arbitration resumes in IDLE.
          r_state     <= S_IDLE;
          r_cpu_ack   <= 1'b0;
          r_dma_ack   <= 1'b0;
          r_owner_dma <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.dma_ack   = r_dma_ack;
  assign bus.dma_rdata = r_dma_rdata;
  assign bus.owner_dma = r_owner_dma;

  // The owner must hold its request until the access is acknowledged.
  a_req_held : assert property (@(posedge clk) disable iff (rst)
    ((r_state == S_ACCESS) || (r_state == S_WAIT)) |->
      (r_owner_dma ? bus.dma_req : bus.cpu_req));

endmodule
